// File: rtl/uart_tx_fifo.sv
// Purpose: byte FIFO in front of uart_tx; launches one stored byte per frame via a tx_enable pulse.
// Latency: a byte written into an empty FIFO launches on the next edge when uart_tx is idle.
// Backpressure: o_wr_ready drops while full; writes offered while full are dropped and set o_overflow.
// Ports: i_clk, i_rst (synchronous, active-high);
//        i_wr_valid/i_wr_data/o_wr_ready producer write port;
//        o_tx_enable/o_tx_data/i_tx_busy uart_tx launch handshake;
//        o_count/o_empty/o_full fill status; o_overflow sticky drop flag, cleared by i_clr_ovf.
module uart_tx_fifo #(
    parameter int Depth       = 16,
    parameter int AddrWidth   = 4,
    parameter int BusyTimeout = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_valid,
    input  logic [7:0]           i_wr_data,
    output logic                 o_wr_ready,
    output logic                 o_tx_enable,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_busy,
    output logic [AddrWidth:0]   o_count,
    output logic                 o_empty,
    output logic                 o_full,
    output logic                 o_overflow,
    input  logic                 i_clr_ovf
);

    localparam int                  TmoWidth  = (BusyTimeout > 1) ? $clog2(BusyTimeout) : 1;
    localparam logic [AddrWidth:0]  FullCount = (AddrWidth + 1)'(Depth);
    localparam logic [TmoWidth-1:0] TmoLast   = TmoWidth'(BusyTimeout - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           mem_q [Depth];
    logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrWidth:0]   count_q, count_d;
    logic [TmoWidth-1:0]  tmo_q, tmo_d;
    logic                 tx_enable_q, tx_enable_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 overflow_q, overflow_d;
    logic                 wr_accept;
    logic                 launch;

    // ------------------------------------------------------------------
    // Write side and fill count
    // ------------------------------------------------------------------
    always_comb begin
        // Ready comes from the registered count, so a pop in the same
        // cycle cannot make room for a write offered while full.
        wr_accept = i_wr_valid && !o_full;
        wr_ptr_d  = wr_accept ? wr_ptr_q + AddrWidth'(1) : wr_ptr_q;

        count_d = count_q;
        case ({wr_accept, launch})
            2'b10:   count_d = count_q + (AddrWidth + 1)'(1);
            2'b01:   count_d = count_q - (AddrWidth + 1)'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over clear.
        if (i_wr_valid && o_full) begin
            overflow_d = 1'b1;
        end else if (i_clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state and busy-wait timeout
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // A transmitter that never raises busy must not stall the
                // queue; after the timeout the byte is treated as sent.
                if (i_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == TmoLast) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TmoWidth'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer: outputs (launch pop, data hold, read pointer)
    // ------------------------------------------------------------------
    always_comb begin
        // Launch sees only the registered count, so a byte written this
        // edge is popped no earlier than the next one.
        launch      = (state_q == ST_IDLE) && (count_q != '0) && !i_tx_busy;
        tx_enable_d = launch;
        tx_data_d   = launch ? mem_q[rd_ptr_q] : tx_data_q;
        rd_ptr_d    = launch ? rd_ptr_q + AddrWidth'(1) : rd_ptr_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            tx_enable_q <= 1'b0;
            tx_data_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            tx_enable_q <= tx_enable_d;
            tx_data_q   <= tx_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign o_count     = count_q;
    assign o_empty     = (count_q == '0);
    assign o_full      = (count_q == FullCount);
    assign o_wr_ready  = ~o_full;
    assign o_tx_enable = tx_enable_q;
    assign o_tx_data   = tx_data_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose: self-checking bench for uart_tx_fifo against a queue-based model.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: the model decides acceptance from its own occupancy, not from o_wr_ready.
module tb_uart_tx_fifo;

    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int BUSY_TIMEOUT = 8;

    localparam int BM_MANUAL = 0;  // bench drives i_tx_busy directly
    localparam int BM_HIGH   = 1;  // busy stuck high
    localparam int BM_LOW    = 2;  // busy stuck low (no transmitter response)
    localparam int BM_RESP   = 3;  // behaves like uart_tx: busy for a few cycles per launch

    logic              clk;
    logic              i_rst;
    logic              i_wr_valid;
    logic [7:0]        i_wr_data;
    logic              o_wr_ready;
    logic              o_tx_enable;
    logic [7:0]        o_tx_data;
    logic              i_tx_busy;
    logic [ADDR_W:0]   o_count;
    logic              o_empty;
    logic              o_full;
    logic              o_overflow;
    logic              i_clr_ovf;

    uart_tx_fifo #(
        .Depth       (DEPTH),
        .AddrWidth   (ADDR_W),
        .BusyTimeout (BUSY_TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_wr_valid  (i_wr_valid),
        .i_wr_data   (i_wr_data),
        .o_wr_ready  (o_wr_ready),
        .o_tx_enable (o_tx_enable),
        .o_tx_data   (o_tx_data),
        .i_tx_busy   (i_tx_busy),
        .o_count     (o_count),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .i_clr_ovf   (i_clr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int         errors    = 0;
    int         checks    = 0;
    int         cyc       = 0;
    int         pulses    = 0;
    int         peak      = 0;
    int         acc_total = 0;
    int         busy_mode = BM_MANUAL;
    int         busy_left = 0;
    bit         ext_busy_en = 1'b0;
    logic       prev_en   = 1'b0;
    logic       movf      = 1'b0;
    logic [7:0] last_tx   = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] launched[$];
    int         pulse_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: capture inputs, advance, update model, compare, drive busy stub.
    task automatic cycle();
        logic       rst_b, wv_b, clr_b, busy_b, acc;
        logic [7:0] d_b;
        rst_b  = i_rst;
        wv_b   = i_wr_valid;
        clr_b  = i_clr_ovf;
        busy_b = i_tx_busy;
        d_b    = i_wr_data;
        acc    = !rst_b && wv_b && (exp_q.size() < DEPTH);
        if (rst_b)                               movf = 1'b0;
        else if (wv_b && exp_q.size() == DEPTH)  movf = 1'b1;
        else if (clr_b)                          movf = 1'b0;

        @(posedge clk);
        #1;
        cyc++;

        if (rst_b) begin
            exp_q.delete();
            last_tx = 8'h00;
            chk("reset_tx_enable", 32'(o_tx_enable), 0);
        end else begin
            // Pop before push: a byte written this edge cannot launch this edge.
            if (o_tx_enable) begin
                pulses++;
                launched.push_back(o_tx_data);
                pulse_cyc.push_back(cyc);
                chk("launch_busy_low", 32'(busy_b), 0);
                chk("pulse_one_cycle", 32'(prev_en), 0);
                chk("launch_has_data", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) last_tx = exp_q.pop_front();
            end
            if (acc) begin
                exp_q.push_back(d_b);
                acc_total++;
            end
        end

        chk("tx_data",  32'(o_tx_data),  32'(last_tx));
        chk("count",    32'(o_count),    32'(exp_q.size()));
        chk("empty",    32'(o_empty),    32'(exp_q.size() == 0));
        chk("full",     32'(o_full),     32'(exp_q.size() == DEPTH));
        chk("wr_ready", 32'(o_wr_ready), 32'(exp_q.size() != DEPTH));
        chk("overflow", 32'(o_overflow), 32'(movf));
        if (int'(o_count) > peak) peak = int'(o_count);
        prev_en = o_tx_enable;

        case (busy_mode)
            BM_HIGH: i_tx_busy = 1'b1;
            BM_LOW:  i_tx_busy = 1'b0;
            BM_RESP: begin
                if (o_tx_enable) begin
                    i_tx_busy = 1'b1;
                    busy_left = int'($urandom_range(2, 6));
                end else if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) i_tx_busy = 1'b0;
                end else begin
                    i_tx_busy = ext_busy_en ? ($urandom_range(0, 15) == 0) : 1'b0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        i_wr_valid = 1'b0;
        i_clr_ovf  = 1'b0;
        while ((exp_q.size() != 0 || i_tx_busy || busy_left != 0) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk("drain_within_budget", 32'(n < max_cyc), 1);
        repeat (3) cycle();
    endtask

    typedef struct {
        logic       rst;
        logic       wv;
        logic [7:0] d;
        logic       busy;
        logic       clr;
        logic       en;
        logic [7:0] dat;
        logic [4:0] cnt;
        logic       ovf;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl[NV];

    initial begin
        logic [7:0] burst[4];
        int         base;
        int         wcyc;
        int         p0;
        int         p1;

        i_rst      = 1'b1;
        i_wr_valid = 1'b0;
        i_wr_data  = 8'h00;
        i_tx_busy  = 1'b0;
        i_clr_ovf  = 1'b0;

        //            rst   wv    d      busy  clr    en    dat    cnt   ovf
        tbl[0]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 5'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55, 5'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h68, 1'b1, 1'b0, 1'b0, 8'h55, 5'd1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h17, 1'b1, 1'b0, 1'b0, 8'h55, 5'd2, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 5'd2, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h68, 5'd1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h68, 5'd1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h68, 5'd1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h68, 5'd1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h68, 5'd1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h17, 5'd0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h17, 5'd0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h17, 5'd0, 1'b0};

        // Reset with writes offered, single-byte latency, launch blocked by external busy.
        busy_mode = BM_MANUAL;
        for (int i = 0; i < NV; i++) begin
            i_rst      = tbl[i].rst;
            i_wr_valid = tbl[i].wv;
            i_wr_data  = tbl[i].d;
            i_tx_busy  = tbl[i].busy;
            i_clr_ovf  = tbl[i].clr;
            cycle();
            chk($sformatf("vec%0d_tx_enable", i), 32'(o_tx_enable), 32'(tbl[i].en));
            chk($sformatf("vec%0d_tx_data", i),   32'(o_tx_data),   32'(tbl[i].dat));
            chk($sformatf("vec%0d_count", i),     32'(o_count),     32'(tbl[i].cnt));
            chk($sformatf("vec%0d_overflow", i),  32'(o_overflow),  32'(tbl[i].ovf));
        end
        i_rst      = 1'b0;
        i_wr_valid = 1'b0;
        i_tx_busy  = 1'b0;

        // Burst of four bytes with a responding transmitter.
        burst       = '{8'd104, 8'd23, 8'd126, 8'd85};
        busy_mode   = BM_RESP;
        busy_left   = 0;
        ext_busy_en = 1'b0;
        base        = launched.size();
        peak        = 0;
        for (int i = 0; i < 4; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = burst[i];
            cycle();
        end
        drain(200);
        chk("burst_peak_count", 32'(peak), 3);
        chk("burst_pulses", 32'(launched.size() - base), 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < launched.size())
                chk($sformatf("burst_byte%0d", i), 32'(launched[base + i]), 32'(burst[i]));
        end

        // Fill to full with busy held high, overflow set/clear, pop-with-write while full.
        busy_mode = BM_HIGH;
        i_tx_busy = 1'b1;
        base      = launched.size();
        for (int b = 0; b < 17; b++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = 8'(b);
            cycle();
            if (b == 15) begin
                chk("full_after_16", 32'(o_full), 1);
                chk("ready_after_16", 32'(o_wr_ready), 0);
                chk("ovf_not_yet", 32'(o_overflow), 0);
            end
        end
        chk("ovf_after_17th", 32'(o_overflow), 1);
        chk("count_after_17th", 32'(o_count), 16);
        i_clr_ovf = 1'b1;
        cycle();
        chk("ovf_set_beats_clear", 32'(o_overflow), 1);
        i_wr_valid = 1'b0;
        cycle();
        chk("ovf_cleared", 32'(o_overflow), 0);
        i_clr_ovf  = 1'b0;
        busy_mode  = BM_RESP;
        busy_left  = 0;
        i_tx_busy  = 1'b0;
        i_wr_valid = 1'b1;
        i_wr_data  = 8'hEE;
        cycle();
        chk("full_pop_launch", 32'(o_tx_enable), 1);
        chk("full_pop_write_count", 32'(o_count), 15);
        chk("full_pop_write_ovf", 32'(o_overflow), 1);
        i_wr_valid = 1'b0;
        i_clr_ovf  = 1'b1;
        cycle();
        i_clr_ovf = 1'b0;
        drain(400);
        chk("full_drain_pulses", 32'(launched.size() - base), 16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < launched.size())
                chk($sformatf("full_byte%0d", i), 32'(launched[base + i]), 32'(i));
        end

        // Busy never rises: each launch is retired after the timeout.
        // WAIT_BUSY lasts BusyTimeout edges, so launches are BusyTimeout+1 apart.
        busy_mode  = BM_LOW;
        i_tx_busy  = 1'b0;
        base       = pulse_cyc.size();
        i_wr_valid = 1'b1;
        i_wr_data  = 8'hA1;
        cycle();
        wcyc       = cyc;
        i_wr_data  = 8'hA2;
        cycle();
        i_wr_valid = 1'b0;
        repeat (24) cycle();
        p0 = (pulse_cyc.size() > base)     ? pulse_cyc[base]     : -1000;
        p1 = (pulse_cyc.size() > base + 1) ? pulse_cyc[base + 1] : -1000;
        chk("timeout_pulses", 32'(pulse_cyc.size() - base), 2);
        chk("write_to_launch", 32'(p0 - wcyc), 1);
        chk("timeout_spacing", 32'(p1 - p0), BUSY_TIMEOUT + 1);

        // Reset while waiting for the frame to finish with five bytes queued.
        busy_mode  = BM_MANUAL;
        i_tx_busy  = 1'b0;
        i_wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) i_tx_busy = 1'b1;
            i_wr_data = 8'(8'h30 + i);
            cycle();
        end
        i_wr_valid = 1'b0;
        chk("queued_before_reset", 32'(o_count), 5);
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        chk("count_after_reset", 32'(o_count), 0);
        base = pulses;
        repeat (3) cycle();
        i_tx_busy = 1'b0;
        repeat (20) cycle();
        chk("no_pulse_after_reset", 32'(pulses - base), 0);

        // Randomised traffic: varying write rate, clears, rare resets, external busy.
        busy_mode   = BM_RESP;
        busy_left   = 0;
        ext_busy_en = 1'b1;
        acc_total   = 0;
        for (int blk = 0; blk < 15; blk++) begin
            int unsigned pct;
            pct = $urandom_range(5, 95);
            for (int j = 0; j < 200; j++) begin
                i_wr_valid = ($urandom_range(0, 99) < pct);
                i_wr_data  = 8'($urandom);
                i_clr_ovf  = ($urandom_range(0, 29) == 0);
                i_rst      = ($urandom_range(0, 599) == 0);
                cycle();
            end
        end
        i_rst       = 1'b0;
        ext_busy_en = 1'b0;
        drain(3000);
        chk("random_enough_writes", 32'(acc_total >= 40), 1);
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        chk("final_empty_flag", 32'(o_empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
